set_job_sequencer: RTL and testbench
====================================

Name: set_job_sequencer

Overview:
- Initiator-side sequencer for the SET circle-candidate engine; it is the host end of the engine's en/busy/valid protocol.
- Accepts job descriptors (three circle centrals, three radii, mode) on a ready/valid input.
- Buffers jobs in a small FIFO and issues them one at a time as a single-cycle set_en pulse.
- Waits for the engine's busy/valid completion, captures the candidate count and returns it on a ready/valid result port with a job tag.
- Includes a watchdog that flags engines that never complete.

Parameters:
DEPTH, 4, job FIFO entries (power of two, 2..16).
TAG_W, 4, job tag width; tag increments per accepted job, wraps.
TIMEOUT, 255, max cycles from set_en to set_valid before abort.

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-high.
job_valid  input  1  job descriptor present.
job_ready  output  1  FIFO not full.
job_central  input  24  {A[23:16],B[15:8],C[7:0]} centres, 4-bit x / 4-bit y each.
job_radius  input  12  {A[11:8],B[7:4],C[3:0]} radii.
job_mode  input  2  engine mode 00..11.
set_en  output  1  one-cycle engine start pulse.
set_central  output  24  registered central for the issued job.
set_radius  output  12  registered radius.
set_mode  output  2  registered mode.
set_busy  input  1  engine busy.
set_valid  input  1  engine one-cycle done pulse.
set_candidate  input  8  engine candidate count, valid with set_valid.
res_valid  output  1  result held.
res_ready  input  1  result consumer accepts.
res_tag  output  TAG_W  tag of completed job.
res_candidate  output  8  captured count (8'h00 on timeout).
res_error  output  1  1 = job aborted by watchdog.
idle  output  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset values:
  - All outputs 0, except job_ready=1 and idle=1.
  - FIFO empty, tag counter 0, FSM IDLE, watchdog 0.
  - rst mid-job discards FIFO contents and any in-flight job; no result is produced.
- FIFO:
  - Push on job_valid&&job_ready. The stored tag equals the tag counter, which then increments mod 2^TAG_W.
  - job_ready = !full.
  - Simultaneous push and pop when full is not allowed (ready=0). Simultaneous push and pop when not full keeps the count unchanged.
  - Pop occurs only in the ISSUE state.
- FSM:
  - IDLE: if FIFO non-empty -> ISSUE.
  - ISSUE (1 cycle): pop the head; register set_central/radius/mode and the tag. set_en=1 in the cycle after ISSUE (registered). Clear the watchdog. -> WAIT_BUSY.
  - WAIT_BUSY: wait for set_busy=1 -> WAIT_DONE. If set_valid is seen here first, treat it as done.
  - WAIT_DONE: on set_valid=1, capture set_candidate and set res_error=0 -> RESULT. set_busy falling without valid is ignored; only set_valid completes.
  - Watchdog:
    - Counts cycles in WAIT_BUSY and WAIT_DONE.
    - When it reaches TIMEOUT: res_candidate=0, res_error=1 -> RESULT.
    - If set_valid and timeout coincide, set_valid wins.
  - RESULT:
    - res_valid=1, with tag, candidate and error held stable until res_valid&&res_ready.
    - On accept, res_valid drops the next cycle -> IDLE.
    - No new set_en is issued while a result is unaccepted.
- set_en is never asserted while set_busy=1. The engine restarts on en regardless, so this is required.
- Outputs set_central/radius/mode stay stable from set_en until the next ISSUE.
- Latency: job accepted into an empty FIFO with the FSM in IDLE -> set_en 3 cycles later (push, IDLE->ISSUE, ISSUE->set_en).
- Throughput: one job per engine run plus 4 cycles of overhead when res_ready is held at 1.
- idle = (state==IDLE) && FIFO empty.

Test Plan:
1. Single job: central=24'h334455, radius=12'h321, mode=00; the engine model asserts busy 1 cycle after en and valid with candidate=8'd17 after 24 cycles. Required: set_en exactly once, 3 cycles after the push. Result: res_tag=0, res_candidate=17, res_error=0. idle returns to 1 after accept.
2. Back-to-back: push 5 jobs with DEPTH=4. Required: job_ready=0 after the 4th push while the 1st is still queued, 5th accepted once space frees. Results appear in order with tags 0,1,2,3,4; no set_en occurs while busy=1.
3. Backpressure: res_ready=0 for 10 cycles after res_valid. Required: outputs stable for those cycles, no second set_en until accept, next job issued after accept.
4. Timeout with TIMEOUT=20: the engine never asserts valid. Required: res_error=1 and res_candidate=0 exactly 20 cycles after set_en; the next job then issues normally.
5. Coincidence: set_valid arrives on the same cycle the watchdog reaches TIMEOUT. Required: res_error=0 and the candidate is captured.
6. Reset mid-job: rst is asserted during WAIT_DONE with 2 jobs queued. Required: all outputs return to reset values immediately, no res_valid afterwards, and the tag restarts at 0 for the next push.

Source files
------------

// File: rtl/set_job_sequencer_if.sv
// set_job_sequencer_if: job input, engine en/busy/valid and result port bundle of the sequencer
interface set_job_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             job_valid;
    logic             job_ready;
    logic [23:0]      job_central;
    logic [11:0]      job_radius;
    logic [1:0]       job_mode;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy;
    logic             set_valid;
    logic [7:0]       set_candidate;
    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_tag;
    logic [7:0]       res_candidate;
    logic             res_error;
    logic             idle;

    modport master (
        input  job_valid, job_central, job_radius, job_mode,
        input  set_busy, set_valid, set_candidate, res_ready,
        output job_ready, set_en, set_central, set_radius, set_mode,
        output res_valid, res_tag, res_candidate, res_error, idle
    );

    modport slave (
        output job_valid, job_central, job_radius, job_mode,
        output set_busy, set_valid, set_candidate, res_ready,
        input  job_ready, set_en, set_central, set_radius, set_mode,
        input  res_valid, res_tag, res_candidate, res_error, idle
    );
endinterface

// File: rtl/set_job_sequencer.sv
// set_job_sequencer: queues SET engine jobs, issues them one at a time, returns tagged candidate counts
module set_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst,
    set_job_sequencer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [23:0]      central;
        logic [11:0]      radius;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
    } job_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESULT} state_t;

    state_t           state_q, state_d;
    job_t             mem_q [DEPTH];
    job_t             cur_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic [TAG_W-1:0] tag_q;
    logic [WW-1:0]    wd_q;
    logic [7:0]       cand_q;
    logic             en_q, err_q;
    logic             push, pop, empty, waiting, timeout, done;

    assign empty   = cnt_q == '0;
    assign push    = bus.job_valid && bus.job_ready;
    assign pop     = state_q == ISSUE;
    assign waiting = state_q inside {WAIT_BUSY, WAIT_DONE};
    assign timeout = wd_q == WW'(TIMEOUT - 1);
    assign done    = waiting && (bus.set_valid || timeout);

    // Holding off ISSUE while busy keeps set_en from restarting an engine still running
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = (!empty && !bus.set_busy) ? ISSUE : IDLE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = done ? RESULT : bus.set_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_d = done ? RESULT : WAIT_DONE;
            RESULT:    state_d = bus.res_ready ? IDLE : RESULT;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {bus.job_central, bus.job_radius, bus.job_mode, tag_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            wd_q    <= '0;
            en_q    <= 1'b0;
            cur_q   <= '0;
            cand_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            tag_q   <= tag_q + TAG_W'(push);
            en_q    <= pop;
            wd_q    <= pop ? '0 : waiting ? wd_q + WW'(1) : wd_q;
            if (pop) cur_q <= mem_q[rd_q];
            // A completion landing on the timeout cycle still counts as a real result
            if (done) begin
                cand_q <= bus.set_valid ? bus.set_candidate : 8'h00;
                err_q  <= !bus.set_valid;
            end
        end
    end

    assign bus.job_ready     = cnt_q != (AW+1)'(DEPTH);
    assign bus.set_en        = en_q;
    assign bus.set_central   = cur_q.central;
    assign bus.set_radius    = cur_q.radius;
    assign bus.set_mode      = cur_q.mode;
    assign bus.res_valid     = state_q == RESULT;
    assign bus.res_tag       = cur_q.tag;
    assign bus.res_candidate = cand_q;
    assign bus.res_error     = err_q;
    assign bus.idle          = state_q == IDLE && empty;
endmodule

// File: tb/tb_set_job_sequencer.sv
// tb_set_job_sequencer: randomized jobs and engine behaviour checked against a job-level timing model
module tb_set_job_sequencer;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int TO    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    set_job_sequencer_if #(.TAG_W(TAG_W)) bus ();
    set_job_sequencer_if #(.TAG_W(TAG_W)) bus1 ();

    set_job_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    set_job_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Job-level model: set_en lands 3 cycles after max(push cycle, previous accept cycle)
    typedef struct {
        logic [37:0]      d;
        logic [TAG_W-1:0] tag;
        int               p;
    } mj_t;

    mj_t              q[$];
    mj_t              cur, lastj;
    bit               fl = 0, issued = 0;
    int               en_c = -100, res_c = -1, last_acc = -100;
    logic [7:0]       e_cand = 0;
    logic             e_err = 0;
    logic [TAG_W-1:0] tag_ctr = 0;

    always @(negedge clk) begin : model
        bit  rv, rdy;
        int  h;
        mj_t j;
        if (rst) begin
            chk("rst_job_ready", bus.job_ready, 1);
            chk("rst_idle", bus.idle, 1);
            chk("rst_outputs", {bus.set_en, bus.set_central, bus.set_radius, bus.set_mode, bus.res_valid,
                                bus.res_tag, bus.res_candidate, bus.res_error}, 0);
            q.delete();
            fl = 0; issued = 0; en_c = -100; res_c = -1; last_acc = -100; tag_ctr = 0;
        end else begin
            rdy = q.size() < DEPTH;
            rv  = fl && res_c >= 0 && cyc >= res_c;
            chk("job_ready", bus.job_ready, rdy);
            chk("set_en", bus.set_en, fl && cyc == en_c);
            chk("set_job", {bus.set_central, bus.set_radius, bus.set_mode}, issued ? lastj.d : 38'd0);
            chk("res_valid", bus.res_valid, rv);
            chk("idle", bus.idle, !fl && q.size() == 0);
            if (bus.set_en) chk("en_while_busy", bus.set_busy, 0);
            if (rv) begin
                chk("res_tag", bus.res_tag, cur.tag);
                chk("res_candidate", bus.res_candidate, e_cand);
                chk("res_error", bus.res_error, e_err);
            end
            if (fl && res_c < 0) begin
                if (bus.set_valid) begin
                    res_c = cyc + 1; e_cand = bus.set_candidate; e_err = 0;
                end else if (cyc == en_c + TO - 1) begin
                    res_c = cyc + 1; e_cand = 0; e_err = 1;
                end
            end else if (rv && bus.res_ready) begin
                fl = 0; last_acc = cyc;
            end
            if (!fl && q.size() > 0) begin
                h = (q[0].p > last_acc ? q[0].p : last_acc) + 2;
                if (h == cyc) begin
                    cur = q.pop_front(); lastj = cur; issued = 1; fl = 1; en_c = cyc + 1; res_c = -1;
                end
            end
            if (bus.job_valid && rdy) begin
                j.d = {bus.job_central, bus.job_radius, bus.job_mode}; j.tag = tag_ctr; j.p = cyc;
                q.push_back(j);
                tag_ctr++;
            end
        end
    end

    int en_at = -1000, lat = 0, force_lat = -1;
    bit t1_done = 0;

    task automatic step(input int pj, input int pr);
        int r;
        @(posedge clk);
        #1;
        if (bus.set_en) begin
            en_at = cyc;
            r = $urandom_range(0, 9);
            lat = force_lat >= 0 ? force_lat : r == 0 ? 1000 : r == 1 ? 19 : r == 2 ? 20 : $urandom_range(1, 18);
        end
        bus.set_busy      = cyc >= en_at + 1 && cyc <= en_at + (lat < 15 ? lat : 15);
        bus.set_valid     = cyc == en_at + lat;
        bus.set_candidate = 8'($urandom);
        bus.job_valid     = $urandom_range(0, 99) < pj;
        bus.job_central   = 24'($urandom);
        bus.job_radius    = 12'($urandom);
        bus.job_mode      = 2'($urandom);
        bus.res_ready     = $urandom_range(0, 99) < pr;
    endtask

    initial begin : main
        bit reached;
        bit seen;
        bus.job_valid = 0; bus.job_central = 0; bus.job_radius = 0; bus.job_mode = 0;
        bus.set_busy = 0; bus.set_valid = 0; bus.set_candidate = 0; bus.res_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (200) step(30, 70);
        repeat (100) step(90, 20);
        repeat (40) step(60, 0);
        force_lat = 1000;
        repeat (150) step(40, 80);
        force_lat = 19;
        repeat (150) step(40, 80);
        force_lat = -1;
        repeat (400) step(60, 50);
        repeat (200) step(0, 100);
        repeat (5) step(100, 100);
        repeat (200) step(0, 100);
        force_lat = 1000;
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            step(100, 100);
            reached = fl && res_c < 0 && cyc >= en_c + 2 && q.size() >= 2;
        end
        chk("reset_scenario_reached", reached, 1);
        rst = 1;
        bus.job_valid = 0; bus.set_busy = 0; bus.set_valid = 0;
        en_at = -1000;
        @(posedge clk);
        #1 rst = 0;
        force_lat = 5;
        step(100, 100);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(0, 100);
            if (bus.res_valid) begin
                seen = 1;
                chk("tag_after_reset", bus.res_tag, 0);
                chk("err_after_reset", bus.res_error, 0);
            end
        end
        chk("result_after_reset", seen, 1);
        repeat (30) step(0, 100);
        for (int i = 0; i < 200 && !t1_done; i++) @(posedge clk);
        chk("single_job_test_done", t1_done, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Single job on a default-TIMEOUT instance: engine busy after en, valid 24 cycles after en
    initial begin : t1
        int p, e, r, ne;
        e = -1; r = -1; ne = 0;
        bus1.job_valid = 0; bus1.job_central = 0; bus1.job_radius = 0; bus1.job_mode = 0;
        bus1.set_busy = 0; bus1.set_valid = 0; bus1.set_candidate = 0; bus1.res_ready = 0;
        @(negedge rst);
        @(posedge clk);
        #1;
        bus1.job_valid = 1; bus1.job_central = 24'h334455; bus1.job_radius = 12'h321; bus1.job_mode = 2'b00;
        p = cyc;
        @(posedge clk);
        #1 bus1.job_valid = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus1.set_en) begin
                ne++;
                if (e < 0) e = cyc;
            end
            if (e >= 0 && cyc >= e) chk("t1_set_job", {bus1.set_central, bus1.set_radius, bus1.set_mode},
                                         {24'h334455, 12'h321, 2'b00});
            bus1.set_busy      = e >= 0 && cyc >= e + 1 && cyc < e + 24;
            bus1.set_valid     = e >= 0 && cyc == e + 24;
            bus1.set_candidate = 8'd17;
            if (bus1.res_valid && r < 0) begin
                r = cyc;
                chk("t1_res_tag", bus1.res_tag, 0);
                chk("t1_res_candidate", bus1.res_candidate, 17);
                chk("t1_res_error", bus1.res_error, 0);
            end
            if (r >= 0 && cyc == r + 1) begin
                chk("t1_res_valid_drop", bus1.res_valid, 0);
                chk("t1_idle_after_accept", bus1.idle, 1);
            end
            bus1.res_ready = bus1.res_valid;
        end
        chk("t1_en_latency", e, p + 3);
        chk("t1_res_cycle", r, p + 28);
        chk("t1_en_count", ne, 1);
        t1_done = 1;
    end
endmodule
